// File: rtl/cable_pkg.sv
// cable_pkg: shared RX state type and TX idle-pattern helper for cable_link.
package cable_pkg;
  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} rx_state_e;
  function automatic logic [31:0] idle_word(input int unsigned phase, input int unsigned out_w);
    logic [31:0] w;
    w = (out_w >= 32) ? '1 : ((32'd1 << out_w) - 32'd1);
    return w & ~(32'd1 << (out_w - 1 - phase));
  endfunction
endpackage

// File: rtl/cable_link_rx.sv
// cable_link_rx: lock FSM on the idle stream, hit decode with timestamp, link error counter.
module cable_link_rx
  import cable_pkg::*;
#(
  parameter int IN_W     = 8,
  parameter int IDLE_IN  = 0,
  parameter int LOCK_CNT = 16,
  parameter int ERR_MAX  = 4,
  parameter int TS_W     = 16,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_W-1:0]     word_i,
  input  logic [TS_W-1:0]     ts_i,
  input  logic                err_clr_i,
  output logic                locked_o,
  output logic                lock_lost_o,
  output logic                hit_valid_o,
  output logic [IN_W-2:0]     hit_data_o,
  output logic [TS_W-1:0]     hit_ts_o,
  output logic [ERRCNT_W-1:0] err_count_o
);
  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(ERR_MAX + 1);
  rx_state_e state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic [EW-1:0] errrun_q, errrun_d;
  logic [ERRCNT_W-1:0] err_q, err_d;
  logic is_idle, is_hit, is_bad, in_lock, lock_hit, drop;
  assign is_idle  = word_i == IN_W'(IDLE_IN);
  assign is_hit   = ~is_idle & word_i[IN_W-1];
  assign is_bad   = ~is_idle & ~is_hit;
  assign in_lock  = state_q == LOCKED;
  assign lock_hit = is_idle && run_q == RW'(LOCK_CNT - 1);
  assign drop     = is_bad && errrun_q == EW'(ERR_MAX - 1);
  always_ff @(posedge clk)
    state_q <= rst ? HUNT : state_d;
  // Any encoding other than a stable LOCKED falls back to HUNT.
  always_comb
    state_d = (state_q == HUNT) ? (lock_hit ? LOCKED : HUNT)
            : (state_q == LOCKED && !drop) ? LOCKED : HUNT;
  always_comb
    locked_o = state_q == LOCKED;
  always_comb begin
    run_d    = (in_lock || !is_idle || lock_hit) ? '0 : run_q + RW'(1);
    errrun_d = (!in_lock || !is_bad || drop) ? '0 : errrun_q + EW'(1);
    err_d    = err_clr_i ? '0 : (in_lock && is_bad && err_q != '1) ? err_q + ERRCNT_W'(1) : err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q       <= '0;
      errrun_q    <= '0;
      err_q       <= '0;
      hit_valid_o <= 1'b0;
      hit_data_o  <= '0;
      hit_ts_o    <= '0;
      lock_lost_o <= 1'b0;
    end else begin
      run_q       <= run_d;
      errrun_q    <= errrun_d;
      err_q       <= err_d;
      hit_valid_o <= in_lock & is_hit;
      lock_lost_o <= in_lock & drop;
      if (in_lock && is_hit) begin
        hit_data_o <= word_i[IN_W-2:0];
        hit_ts_o   <= ts_i;
      end
    end
  end
  assign err_count_o = err_q;
endmodule

// File: rtl/cable_link.sv
// cable_link: ROCSTAR<->MCU cable endpoint; TX idle/command mux and timestamp here, RX in cable_link_rx.
module cable_link
  import cable_pkg::*;
#(
  parameter int IN_W     = 8,
  parameter int OUT_W    = 4,
  parameter int IDLE_IN  = 0,
  parameter int LOCK_CNT = 16,
  parameter int ERR_MAX  = 4,
  parameter int TS_W     = 16,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tx_en,
  input  logic                cmd_valid,
  input  logic [OUT_W-1:0]    cmd_data,
  output logic                cmd_ready,
  output logic [OUT_W-1:0]    out,
  input  logic [IN_W-1:0]     in,
  output logic                locked,
  output logic                lock_lost,
  output logic                hit_valid,
  output logic [IN_W-2:0]     hit_data,
  output logic [TS_W-1:0]     hit_ts,
  input  logic                err_clr,
  output logic [ERRCNT_W-1:0] err_count
);
  localparam int PW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  logic [PW-1:0] phase_q, phase_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [TS_W-1:0] ts_q;
  assign cmd_ready = tx_en & ~rst;
  // A command steals the slot; the idle rotation resumes where it left off.
  always_comb begin
    out_d   = !tx_en ? '0 : cmd_valid ? cmd_data : OUT_W'(idle_word(32'(phase_q), OUT_W));
    phase_d = (tx_en && !cmd_valid) ? ((phase_q == PW'(OUT_W - 1)) ? '0 : phase_q + PW'(1)) : phase_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      phase_q <= '0;
      ts_q    <= '0;
    end else begin
      out_q   <= out_d;
      phase_q <= phase_d;
      ts_q    <= ts_q + TS_W'(1);
    end
  end
  assign out = out_q;
  cable_link_rx #(
    .IN_W(IN_W), .IDLE_IN(IDLE_IN), .LOCK_CNT(LOCK_CNT),
    .ERR_MAX(ERR_MAX), .TS_W(TS_W), .ERRCNT_W(ERRCNT_W)
  ) u_rx (
    .clk(clk), .rst(rst), .word_i(in), .ts_i(ts_q), .err_clr_i(err_clr),
    .locked_o(locked), .lock_lost_o(lock_lost), .hit_valid_o(hit_valid),
    .hit_data_o(hit_data), .hit_ts_o(hit_ts), .err_count_o(err_count)
  );
endmodule

// File: tb/tb_cable_link.sv
// tb_cable_link: directed scenarios plus randomized traffic against a behavioural cable model.
module tb_cable_link;
  logic clk = 0, rst = 1, tx_en = 0, cmd_valid = 0, err_clr = 0;
  logic [3:0] cmd_data = 0;
  logic [7:0] d_in = 0;
  logic cmd_ready, locked, lock_lost, hit_valid;
  logic [3:0] d_out, err_count;
  logic [6:0] hit_data;
  logic [15:0] hit_ts;
  int checks = 0, errors = 0;
  int m_phase, m_run, m_errrun;
  logic [3:0] m_out, m_err;
  logic [15:0] m_ts, m_hts;
  logic [6:0] m_hd;
  logic m_locked, m_hv, m_ll;

  cable_link #(.ERRCNT_W(4)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .out(d_out), .in(d_in), .locked(locked), .lock_lost(lock_lost),
    .hit_valid(hit_valid), .hit_data(hit_data), .hit_ts(hit_ts), .err_clr(err_clr),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    if (rst) begin
      m_phase = 0; m_run = 0; m_errrun = 0; m_out = 0; m_err = 0; m_ts = 0;
      m_hts = 0; m_hd = 0; m_locked = 0; m_hv = 0; m_ll = 0;
    end else begin
      m_out = !tx_en ? 4'h0 : cmd_valid ? cmd_data : (4'hF & ~(4'h1 << (3 - m_phase)));
      if (tx_en && !cmd_valid) m_phase = (m_phase + 1) % 4;
      m_hv = 0; m_ll = 0;
      if (!m_locked) begin
        m_run = (d_in == 0) ? m_run + 1 : 0;
        if (m_run == 16) begin m_locked = 1; m_run = 0; end
      end else if (d_in == 0) m_errrun = 0;
      else if (d_in[7]) begin
        m_hv = 1; m_hd = d_in[6:0]; m_hts = m_ts; m_errrun = 0;
      end else begin
        m_errrun++;
        m_err = (m_err == 15) ? 4'd15 : m_err + 4'd1;
        if (m_errrun == 4) begin m_locked = 0; m_ll = 1; m_errrun = 0; m_run = 0; end
      end
      if (err_clr) m_err = 0;
      m_ts++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; tx_en = 1; d_in = 8'h55;
    cyc(); cyc();
    checks++;
    if ({d_out, locked, lock_lost, hit_valid, hit_data, hit_ts, err_count} !== 34'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {d_out, locked, lock_lost, hit_valid, hit_data, hit_ts, err_count});
    end
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %b want 0", cmd_ready); end
    d_in = 0; rst = 0;
  endtask

  task automatic test_tx_idle();
    logic [3:0] exp_w [8] = '{4'h7, 4'hB, 4'hD, 4'hE, 4'h7, 4'hB, 4'hD, 4'hE};
    for (int i = 0; i < 8; i++) begin
      cyc();
      checks++;
      if (d_out !== exp_w[i]) begin errors++; $display("FAIL tx_idle[%0d] got %h want %h", i, d_out, exp_w[i]); end
    end
  endtask

  task automatic test_cmd();
    for (int g = 0; g < 4 && m_phase != 2; g++) cyc();
    cmd_valid = 1; cmd_data = 4'hA; #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_on got %b want 1", cmd_ready); end
    cyc();
    checks++;
    if (d_out !== 4'hA) begin errors++; $display("FAIL cmd_out got %h want a", d_out); end
    cmd_valid = 0;
    cyc();
    checks++;
    if (d_out !== 4'hD) begin errors++; $display("FAIL cmd_phase_held got %h want d", d_out); end
    tx_en = 0; #1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL cmd_ready_off got %b want 0", cmd_ready); end
    cyc();
    checks++;
    if (d_out !== 4'h0) begin errors++; $display("FAIL tx_off got %h want 0", d_out); end
  endtask

  task automatic test_lock();
    rst = 1; cyc(); rst = 0;
    d_in = 0; repeat (15) cyc();
    d_in = 8'h01; cyc();
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL lock_15_idles got %b want 0", locked); end
    d_in = 8'h85;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (hit_valid !== 1'b0 || locked !== 1'b0) begin
        errors++; $display("FAIL hunt_hit got hv=%b lk=%b want 0 0", hit_valid, locked);
      end
    end
    checks++;
    if (err_count !== 4'd0) begin errors++; $display("FAIL hunt_no_err got %0d want 0", err_count); end
    d_in = 0; repeat (15) cyc();
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got %b want 0", locked); end
    cyc();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL lock_16 got %b want 1", locked); end
  endtask

  task automatic test_hit();
    d_in = 0;
    for (int g = 0; g < 2000 && m_ts != 16'h0123; g++) cyc();
    d_in = 8'h85; cyc();
    checks++;
    if ({hit_valid, hit_data, hit_ts} !== {1'b1, 7'h05, 16'h0123}) begin
      errors++; $display("FAIL hit1 got %b/%h/%h want 1/05/0123", hit_valid, hit_data, hit_ts);
    end
    d_in = 8'hFF; cyc();
    checks++;
    if ({hit_valid, hit_data, hit_ts} !== {1'b1, 7'h7F, 16'h0124}) begin
      errors++; $display("FAIL hit2 got %b/%h/%h want 1/7f/0124", hit_valid, hit_data, hit_ts);
    end
    d_in = 0; cyc();
    checks++;
    if (hit_valid !== 1'b0 || locked !== 1'b1) begin
      errors++; $display("FAIL hit_end got hv=%b lk=%b want 0 1", hit_valid, locked);
    end
  endtask

  task automatic test_err();
    d_in = 8'h01; repeat (3) cyc();
    d_in = 0; cyc();
    d_in = 8'h01; repeat (3) cyc();
    checks++;
    if (lock_lost !== 1'b0 || locked !== 1'b1) begin
      errors++; $display("FAIL err_3rd got ll=%b lk=%b want 0 1", lock_lost, locked);
    end
    cyc();
    checks++;
    if ({lock_lost, locked, err_count} !== {1'b1, 1'b0, 4'd7}) begin
      errors++; $display("FAIL err_drop got ll=%b lk=%b err=%0d want 1 0 7", lock_lost, locked, err_count);
    end
    d_in = 0; cyc();
    checks++;
    if (lock_lost !== 1'b0 || err_count !== 4'd7) begin
      errors++; $display("FAIL err_pulse got ll=%b err=%0d want 0 7", lock_lost, err_count);
    end
    repeat (15) cyc();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL relock got %b want 1", locked); end
    d_in = 8'h01; err_clr = 1; cyc();
    checks++;
    if (err_count !== 4'd0) begin errors++; $display("FAIL err_clr_wins got %0d want 0", err_count); end
    err_clr = 0; d_in = 0; cyc();
  endtask

  task automatic test_sat();
    for (int i = 0; i < 20; i++) begin
      d_in = 8'h01; cyc();
      d_in = 0; cyc();
    end
    checks++;
    if (err_count !== 4'd15 || locked !== 1'b1) begin
      errors++; $display("FAIL err_sat got err=%0d lk=%b want 15 1", err_count, locked);
    end
    rst = 1; cyc();
    checks++;
    if ({d_out, locked, lock_lost, hit_valid, hit_data, hit_ts, err_count} !== 34'd0) begin
      errors++; $display("FAIL mid_reset got %h want 0", {d_out, locked, lock_lost, hit_valid, hit_data, hit_ts, err_count});
    end
    rst = 0; repeat (15) cyc();
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL post_rst_15 got %b want 0", locked); end
    cyc();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL post_rst_16 got %b want 1", locked); end
  endtask

  task automatic test_random();
    int burst = 0, r;
    rst = 1; cyc(); rst = 0;
    for (int i = 0; i < 1500; i++) begin
      tx_en = ($urandom % 4) != 0;
      cmd_valid = ($urandom % 3) == 0;
      cmd_data = 4'($urandom);
      err_clr = ($urandom % 50) == 0;
      if (burst == 0 && ($urandom % 60) == 0) burst = $urandom_range(3, 6);
      r = $urandom % 100;
      if (burst > 0) begin d_in = {1'b0, 7'($urandom_range(1, 127))}; burst--; end
      else if (r < 85) d_in = 0;
      else if (r < 93) d_in = {1'b1, 7'($urandom)};
      else d_in = {1'b0, 7'($urandom_range(1, 127))};
      #1;
      checks++;
      if (cmd_ready !== tx_en) begin errors++; $display("FAIL rnd_ready[%0d] got %b want %b", i, cmd_ready, tx_en); end
      cyc();
      checks++;
      if ({d_out, locked, lock_lost, hit_valid, hit_data, hit_ts, err_count} !==
          {m_out, m_locked, m_ll, m_hv, m_hd, m_hts, m_err}) begin
        errors++;
        $display("FAIL rnd[%0d] got %h want %h", i, {d_out, locked, lock_lost, hit_valid, hit_data, hit_ts, err_count},
                 {m_out, m_locked, m_ll, m_hv, m_hd, m_hts, m_err});
      end
    end
  endtask

  initial begin
    test_reset();
    test_tx_idle();
    test_cmd();
    test_lock();
    test_hit();
    test_err();
    test_sat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
